// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the architectural PC and reads instruction memory.
// Stops after each branch-class instruction until Execute resolves it.
module fetch_unit #(
    parameter int              PC_WIDTH = 16,
    parameter int              IR_WIDTH = 32,
    parameter int              IMEM_AW  = 10,
    parameter logic [15:0]     RESET_PC = 16'h0000,
    parameter logic [4:0]      BR_CLASS = 5'b11011
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET_N,
    input  logic                I_LOCK,
    input  logic                I_DEStallSignal,
    input  logic                I_BrResolved_Signal,
    input  logic                I_BranchAddrSelect_Signal,
    input  logic [PC_WIDTH-1:0] I_BranchPC_Signal,
    output logic [IMEM_AW-1:0]  O_IMemAddr,
    input  logic [IR_WIDTH-1:0] I_IMemData,
    output logic                O_LOCK,
    output logic [PC_WIDTH-1:0] O_PC,
    output logic [IR_WIDTH-1:0] O_IR,
    output logic                O_FE_Valid,
    output logic [15:0]         O_BrStallCycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        BR_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] opc_q, opc_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                lock_q, lock_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [15:0]         cnt_inc;
    logic                is_br;

    assign O_IMemAddr      = pc_q[IMEM_AW+1:2];
    assign O_LOCK          = lock_q;
    assign O_PC            = opc_q;
    assign O_IR            = ir_q;
    assign O_FE_Valid      = valid_q;
    assign O_BrStallCycles = cnt_q;

    assign pc_inc  = pc_q + PC_WIDTH'(4);
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign is_br   = (I_IMemData[31:27] == BR_CLASS);

    // Next-state: lock drop wins, then redirect, then stall, then fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        lock_d  = I_LOCK;
        cnt_d   = cnt_q;
        if (!I_LOCK) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
                FETCH: begin
                    if (I_BranchAddrSelect_Signal) begin
                        pc_d    = I_BranchPC_Signal;
                        valid_d = 1'b0;
                    end else if (!I_DEStallSignal) begin
                        ir_d    = I_IMemData;
                        opc_d   = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                        if (is_br) begin
                            state_d = BR_WAIT;
                        end
                    end
                end
                BR_WAIT: begin
                    cnt_d = cnt_inc;
                    if (!I_DEStallSignal) begin
                        valid_d = 1'b0;
                    end
                    if (I_BrResolved_Signal) begin
                        if (I_BranchAddrSelect_Signal) begin
                            pc_d = I_BranchPC_Signal;
                        end
                        state_d = FETCH;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers, updated on the falling clock edge.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC[PC_WIDTH-1:0];
            opc_q   <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
